// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: job sequencer for the 4x4 block matrix multiplier datapath.
// Collects 16 A elements and 16 B elements from an element-serial input stream,
// latches the job's format fields, pulses dp_flag, waits a fixed datapath latency,
// captures the 16 C elements and streams them out with valid/ready backpressure.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_m_bit1/2             format fields, sampled on the first accepted beat of a job
//   in_valid/in_ready/in_data   element-serial input, A beats 0-15 then B beats 16-31
//   out_valid/out_ready/out_data/out_last   C result stream, row-major
//   busy                     high whenever a job is in progress
//   dp_A, dp_B               flattened 4x4 operands, element r*4+c at [(r*4+c)*2W +: 2W]
//   dp_m_bit1/2              latched format fields
//   dp_flag                  single-cycle datapath start pulse
//   dp_C                     flattened 4x4 datapath result, same packing as dp_A
module matrix_mult_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            cfg_m_bit1,
    input  logic [4:0]            cfg_m_bit2,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*WIDTH-1:0]    in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [32*WIDTH-1:0]   dp_A,
    output logic [32*WIDTH-1:0]   dp_B,
    output logic [4:0]            dp_m_bit1,
    output logic [4:0]            dp_m_bit2,
    output logic                  dp_flag,
    input  logic [32*WIDTH-1:0]   dp_C
);

    localparam int unsigned EW = 2 * WIDTH;
    localparam int unsigned WW = $clog2(LATENCY) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StWait, StDrain} state_e;

    state_e          state_q, state_d;
    logic [5:0]      beat_cnt_q, beat_cnt_d;
    logic [3:0]      out_idx_q, out_idx_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;

    logic [EW-1:0]   a_q [16];
    logic [EW-1:0]   b_q [16];
    logic [EW-1:0]   c_q [16];
    logic [4:0]      m1_q, m2_q;

    logic            load_a, load_b, latch_cfg, capture;
    logic [3:0]      wr_idx;

    // beat_cnt is 0 in IDLE, so its low nibble addresses A[0][0] for the first beat
    // and wraps naturally onto B[0][0] at beat 16.
    assign wr_idx = beat_cnt_q[3:0];

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        out_idx_d  = out_idx_q;
        wait_cnt_d = wait_cnt_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dp_flag    = 1'b0;
        busy       = 1'b1;
        load_a     = 1'b0;
        load_b     = 1'b0;
        latch_cfg  = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    load_a     = 1'b1;
                    latch_cfg  = 1'b1;
                    beat_cnt_d = 6'd1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (beat_cnt_q < 6'd16) begin
                        load_a = 1'b1;
                    end else begin
                        load_b = 1'b1;
                    end
                    if (beat_cnt_q == 6'd31) begin
                        beat_cnt_d = '0;
                        state_d    = StRun;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 6'd1;
                    end
                end
            end
            StRun: begin
                dp_flag    = 1'b1;
                wait_cnt_d = WW'(LATENCY - 1);
                state_d    = StWait;
            end
            StWait: begin
                if (wait_cnt_q == '0) begin
                    capture   = 1'b1;
                    out_idx_d = '0;
                    state_d   = StDrain;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (out_idx_q == 4'd15) begin
                        out_idx_d = '0;
                        state_d   = StIdle;
                    end else begin
                        out_idx_d = out_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            out_idx_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            out_idx_q  <= out_idx_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Holding and result registers; operands stay put from RUN until capture
    // because only IDLE/LOAD can write them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
            m1_q <= '0;
            m2_q <= '0;
        end else begin
            if (load_a) a_q[wr_idx] <= in_data;
            if (load_b) b_q[wr_idx] <= in_data;
            if (latch_cfg) begin
                m1_q <= cfg_m_bit1;
                m2_q <= cfg_m_bit2;
            end
            if (capture) begin
                for (int i = 0; i < 16; i++) c_q[i] <= dp_C[i*EW +: EW];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign dp_A[g*EW +: EW] = a_q[g];
        assign dp_B[g*EW +: EW] = b_q[g];
    end

    assign dp_m_bit1 = m1_q;
    assign dp_m_bit2 = m2_q;
    assign out_data  = out_valid ? c_q[out_idx_q] : '0;
    assign out_last  = out_valid && (out_idx_q == 4'd15);

endmodule

// File: doc/matrix_mult_seq.md
# matrix_mult_seq

Sequencer for the 4x4 block matrix multiplier datapath. It streams A and B into holding registers one element at a time, latches the per-job format configuration, and pulses the datapath start flag. It then waits the fixed datapath latency, captures C, and streams C out with valid/ready backpressure. It sits between the element-serial system bus and the parallel 4x4 multiply datapath, and runs one job at a time.

## Interface
- WIDTH, 16, half element width; every element is 2*WIDTH bits.
- LATENCY, 24, cycles from the dp_flag pulse to a valid dp_C (minimum 1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_m_bit1  in  5  format field 1, sampled on the first accepted input beat of a job.
- cfg_m_bit2  in  5  format field 2, sampled with cfg_m_bit1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- in_data  in  2*WIDTH  element; beats 0-15 are A and beats 16-31 are B, both row-major ([r][c] = beat r*4+c).
- out_valid  out  1  result beat valid.
- out_ready  in  1  result beat consumed when out_valid and out_ready are both high.
- out_data  out  2*WIDTH  C element, row-major.
- out_last  out  1  high with the 16th result beat (C[3][3]).
- busy  out  1  high in every state except IDLE.
- dp_A, dp_B  out  4x4 x 2*WIDTH  operand matrices to the datapath.
- dp_m_bit1, dp_m_bit2  out  5  latched format fields.
- dp_flag  out  1  single-cycle start pulse.
- dp_C  in  4x4 x 2*WIDTH  datapath result.

## Operation
- States: IDLE, LOAD, RUN, WAIT, DRAIN.
- IDLE:
  - in_ready=1.
  - On an accepted beat: store the element to A[0][0], latch cfg_m_bit1/2, set beat_cnt=1, go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted beat writes A (beat_cnt<16) or B (beat_cnt 16-31), then beat_cnt increments.
  - The accept of beat 31 goes to RUN.
  - Gaps in in_valid are allowed and have no effect.
- RUN: lasts 1 cycle. dp_flag=1, wait counter loads LATENCY-1, go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter is 0: capture all 16 dp_C into the result registers, set out_idx=0, go to DRAIN.
- DRAIN:
  - out_valid=1 and out_data=C[out_idx/4][out_idx%4].
  - Each accepted beat increments out_idx.
  - Accept with out_idx=15 (out_last=1) returns to IDLE.
- Throughout RUN, WAIT and DRAIN:
  - in_ready=0.
  - dp_A, dp_B and dp_m_bit1/2 are held constant from the start of RUN until the capture.
- dp_A/dp_B always reflect the holding registers. They are not cleared between jobs.
- cfg_m_bit changes after the first beat have no effect on the current job.
- Counter widths: beat_cnt 6 bits, out_idx 4 bits, wait counter clog2(LATENCY)+1 bits. No counter wraps; the terminal values are explicit.
- No arithmetic is performed here. Elements pass through bit-exact.

## Timing
- Reset values (asynchronous):
  - State IDLE, in_ready=1.
  - out_valid=0, out_last=0, out_data=0, busy=0, dp_flag=0.
  - dp_A, dp_B, dp_m_bit1/2 and the result registers all 0.
  - All counters 0.
- Last input beat accepted at edge t:
  - dp_flag high in cycle t+1.
  - dp_C sampled at edge t+1+LATENCY.
  - out_valid high from cycle t+2+LATENCY.
- Minimum job time with no stalls: 32 + 1 + LATENCY + 16 cycles.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- in_ready goes high in the cycle after the final output accept, so the next job's first beat can be accepted in that cycle.
- Reset asserted mid-job (any state):
  - Immediate return to IDLE with the reset values above.
  - dp_flag never glitches high.
  - Partial data is discarded.
  - A dp_C value arriving after reset is ignored.
- in_valid during RUN, WAIT or DRAIN is ignored and nothing is stored.

## Test plan
- Datapath stub: the bench uses a stub that returns dp_C[i][j] = dp_A[i][j] + dp_B[i][j], combinationally after LATENCY cycles.
- Basic job, LATENCY=24: A beats 1..16, B beats 100..115 with no gaps, out_ready=1.
  - dp_flag is a single pulse one cycle after beat 31.
  - Outputs are 101,103,...,131, in row-major order, with out_last on 131.
  - First output appears 26 cycles after the last input accept.
- Input gaps plus config latch: in_valid toggles randomly; cfg_m_bit1=5'd7 on the first beat, then changed to 5'd3.
  - dp_m_bit1 = 7 for the whole job.
  - Results are identical to the basic job.
- Output backpressure: out_ready low for 5 cycles at out_idx=0 and at out_idx=15.
  - out_data stays 101 or 131 respectively while stalled.
  - No duplicated or lost beats.
  - in_ready stays 0 until the final accept.
- Back-to-back jobs: a second job starts in the cycle after out_last is accepted.
  - Its first beat is accepted in that cycle.
  - Second-job results are correct, with no residue from job 1.
- Reset mid-WAIT: assert rst_n low 10 cycles after dp_flag.
  - All outputs take their reset values asynchronously.
  - No out_valid appears.
  - A following basic job completes correctly.
- Ignored input: hold in_valid=1 with data 0xDEAD during WAIT and DRAIN.
  - in_ready=0 throughout.
  - The holding registers and results are unchanged.
